// File: rtl/uart_chan_frame_rx_if.sv
// Snapshot output bus: flat per-channel data, dirty mask and valid/ready handshake.
interface uart_chan_frame_rx_if #(
    parameter int NUM_CH = 32,
    parameter int SW     = 8
);
    logic [NUM_CH*SW-1:0] out_data;
    logic [NUM_CH-1:0]    out_dirty;
    logic                 out_valid;
    logic                 out_ready;

    modport master (output out_data, output out_dirty, output out_valid, input out_ready);
    modport slave  (input out_data, input out_dirty, input out_valid, output out_ready);
endinterface

// File: rtl/uart_chan_frame_rx.sv
// UART 8N1 packet receiver: SYNC,CH_ID,SAMPLE[SAMPLE_BYTES],CHK -> per-channel shadow bank,
// snapshotted to a flat bus under valid/ready. Framing/checksum/range/timeout errors counted.
module uart_chan_frame_rx #(
    parameter int         CLK_FRE_MHZ  = 50,
    parameter int         BAUD_RATE    = 128000,
    parameter int         NUM_CH       = 32,
    parameter int         SAMPLE_BYTES = 1,
    parameter logic [7:0] SYNC_BYTE    = 8'hAA,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_pin_i,
    uart_chan_frame_rx_if.master out_if,
    output logic [7:0]           err_frame_o,
    output logic [7:0]           err_chk_o,
    output logic [7:0]           err_chid_o,
    output logic [7:0]           err_timeout_o
);
    localparam int SW     = 8 * SAMPLE_BYTES;
    localparam int CYCLE  = CLK_FRE_MHZ * 1000000 / BAUD_RATE;
    localparam int CW     = $clog2(CYCLE + 1);
    localparam int TO_LIM = TIMEOUT_BITS * CYCLE;
    localparam int TW     = $clog2(TO_LIM + 1);
    localparam int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CW-1:0] CYC_M1 = CW'(CYCLE - 1);
    localparam logic [CW-1:0] HALF   = CW'(CYCLE / 2 - 1);
    localparam logic [TW-1:0] TO_M1  = TW'(TO_LIM - 1);
    localparam logic [1:0]    BC_END = 2'(SAMPLE_BYTES - 1);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_e;
    typedef enum logic [1:0] {P_SYNC, P_CHID, P_DATA, P_CHK}   pstate_e;

    logic [1:0]    sync_q;
    logic          rx_prev_q;
    logic          rx_s;
    bstate_e       bst_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shreg_q;
    logic          byte_vld_q;
    logic          frame_err_q;

    pstate_e       pst_q;
    logic [7:0]    id_q;
    logic [7:0]    chk_q;
    logic [1:0]    bcnt_q;
    logic [SW-1:0] samp_q;
    logic [TW-1:0] to_cnt_q;
    logic [7:0]    err_frame_q, err_chk_q, err_chid_q, err_timeout_q;

    logic [NUM_CH-1:0][SW-1:0] shadow_q;
    logic [NUM_CH-1:0]         dirty_q;
    logic [NUM_CH*SW-1:0]      out_data_q;
    logic [NUM_CH-1:0]         out_dirty_q;
    logic                      out_valid_q;

    logic              id_ok;
    logic              wr_en;
    logic [IW-1:0]     widx;
    logic [NUM_CH-1:0] wr_mask;

    assign rx_s  = sync_q[1];
    assign id_ok = ({1'b0, id_q} < 9'(NUM_CH));
    assign widx  = id_q[IW-1:0];
    assign wr_en = byte_vld_q && (pst_q == P_CHK) && (shreg_q == chk_q) && id_ok;

    // One-hot channel mask for the shadow write happening this clock
    always_comb begin
        wr_mask = '0;
        if (wr_en) wr_mask = NUM_CH'(1) << widx;
    end

    // Two-flop synchroniser plus previous-sample register for start-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], rx_pin_i};
            rx_prev_q <= rx_s;
        end
    end

    // Byte FSM: mid-bit sampling, false-start rejection, stop-bit check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bst_q       <= B_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (bst_q)
                B_IDLE: begin
                    cnt_q <= '0;
                    if (rx_prev_q && !rx_s) bst_q <= B_START;
                end
                B_START: begin
                    if (cnt_q == HALF) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        bst_q <= rx_s ? B_IDLE : B_DATA;
                    end else cnt_q <= cnt_q + CW'(1);
                end
                B_DATA: begin
                    if (cnt_q == CYC_M1) begin
                        cnt_q   <= '0;
                        shreg_q <= {rx_s, shreg_q[7:1]};
                        if (bit_q == 3'd7) bst_q <= B_STOP;
                        else               bit_q <= bit_q + 3'd1;
                    end else cnt_q <= cnt_q + CW'(1);
                end
                B_STOP: begin
                    if (cnt_q == CYC_M1) begin
                        cnt_q <= '0;
                        bst_q <= B_IDLE;
                        if (rx_s) byte_vld_q  <= 1'b1;
                        else      frame_err_q <= 1'b1;
                    end else cnt_q <= cnt_q + CW'(1);
                end
                default: bst_q <= B_IDLE;
            endcase
        end
    end

    // Packet parser, inter-byte timeout and saturating error counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pst_q         <= P_SYNC;
            id_q          <= '0;
            chk_q         <= '0;
            bcnt_q        <= '0;
            samp_q        <= '0;
            to_cnt_q      <= '0;
            err_frame_q   <= '0;
            err_chk_q     <= '0;
            err_chid_q    <= '0;
            err_timeout_q <= '0;
        end else if (frame_err_q) begin
            pst_q       <= P_SYNC;
            to_cnt_q    <= '0;
            err_frame_q <= err_frame_q + {7'd0, err_frame_q != 8'hFF};
        end else if (byte_vld_q) begin
            to_cnt_q <= '0;
            case (pst_q)
                P_SYNC: if (shreg_q == SYNC_BYTE) pst_q <= P_CHID;
                P_CHID: begin
                    id_q   <= shreg_q;
                    chk_q  <= shreg_q;
                    bcnt_q <= '0;
                    samp_q <= '0;
                    pst_q  <= P_DATA;
                end
                P_DATA: begin
                    samp_q <= SW'({samp_q, shreg_q});
                    chk_q  <= chk_q ^ shreg_q;
                    if (bcnt_q == BC_END) pst_q  <= P_CHK;
                    else                  bcnt_q <= bcnt_q + 2'd1;
                end
                P_CHK: begin
                    pst_q <= P_SYNC;
                    if (shreg_q != chk_q) err_chk_q  <= err_chk_q + {7'd0, err_chk_q != 8'hFF};
                    else if (!id_ok)      err_chid_q <= err_chid_q + {7'd0, err_chid_q != 8'hFF};
                end
                default: pst_q <= P_SYNC;
            endcase
        end else if (pst_q != P_SYNC) begin
            if (to_cnt_q == TO_M1) begin
                pst_q         <= P_SYNC;
                to_cnt_q      <= '0;
                err_timeout_q <= err_timeout_q + {7'd0, err_timeout_q != 8'hFF};
            end else to_cnt_q <= to_cnt_q + TW'(1);
        end else begin
            to_cnt_q <= '0;
        end
    end

    // Shadow bank, dirty tracking and snapshot handshake; a write in the snapshot clock
    // stays dirty for the following snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q    <= '0;
            dirty_q     <= '0;
            out_data_q  <= '0;
            out_dirty_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (wr_en) shadow_q[widx] <= samp_q;
            if (out_valid_q) begin
                if (out_if.out_ready) out_valid_q <= 1'b0;
                dirty_q <= dirty_q | wr_mask;
            end else if (|dirty_q) begin
                out_data_q  <= shadow_q;
                out_dirty_q <= dirty_q;
                out_valid_q <= 1'b1;
                dirty_q     <= wr_mask;
            end else begin
                dirty_q <= dirty_q | wr_mask;
            end
        end
    end

    assign out_if.out_data  = out_data_q;
    assign out_if.out_dirty = out_dirty_q;
    assign out_if.out_valid = out_valid_q;
    assign err_frame_o      = err_frame_q;
    assign err_chk_o        = err_chk_q;
    assign err_chid_o       = err_chid_q;
    assign err_timeout_o    = err_timeout_q;
endmodule

// File: tb/tb_uart_chan_frame_rx.sv
// Directed bench: two receivers (1-byte and 2-byte samples) on a 16-clock bit period.
module tb_uart_chan_frame_rx;
    localparam int CYC = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx1 = 1'b1;
    logic rx2 = 1'b1;
    logic [7:0] ef1, ec1, ei1, et1;
    logic [7:0] ef2, ec2, ei2, et2;
    int checks = 0;
    int failures = 0;

    uart_chan_frame_rx_if #(.NUM_CH(32), .SW(8))  if1 ();
    uart_chan_frame_rx_if #(.NUM_CH(32), .SW(16)) if2 ();

    uart_chan_frame_rx #(.CLK_FRE_MHZ(1), .BAUD_RATE(62500), .NUM_CH(32), .SAMPLE_BYTES(1),
                         .SYNC_BYTE(8'hAA), .TIMEOUT_BITS(20)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rx_pin_i(rx1), .out_if(if1.master),
        .err_frame_o(ef1), .err_chk_o(ec1), .err_chid_o(ei1), .err_timeout_o(et1));

    uart_chan_frame_rx #(.CLK_FRE_MHZ(1), .BAUD_RATE(62500), .NUM_CH(32), .SAMPLE_BYTES(2),
                         .SYNC_BYTE(8'hAA), .TIMEOUT_BITS(20)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .rx_pin_i(rx2), .out_if(if2.master),
        .err_frame_o(ef2), .err_chk_o(ec2), .err_chid_o(ei2), .err_timeout_o(et2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx2 = v;
        else     rx1 = v;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b, input logic stop);
        set_line(sel, 1'b0);
        repeat (CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_line(sel, b[i]);
            repeat (CYC) @(negedge clk);
        end
        set_line(sel, stop);
        repeat (CYC) @(negedge clk);
        set_line(sel, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    // Sends the low n bytes of seq, most significant first
    task automatic send_seq(input bit sel, input logic [39:0] seq, input int n);
        for (int k = n - 1; k >= 0; k--) send_byte(sel, seq[k*8 +: 8], 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic pop1;
        @(negedge clk) if1.out_ready = 1'b1;
        @(negedge clk) if1.out_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        if1.out_ready = 1'b0;
        if2.out_ready = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_valid", {63'd0, if1.out_valid}, 64'd0);
        chk("rst_dirty", {32'd0, if1.out_dirty}, 64'd0);
        chk("rst_errs", {32'd0, ef1, ec1, ei1, et1}, 64'd0);

        // basic packet
        send_seq(0, 40'hAA_05_3C_39, 4);
        chk("t1_valid", {63'd0, if1.out_valid}, 64'd1);
        chk("t1_data", {56'd0, if1.out_data[47:40]}, 64'h3C);
        chk("t1_dirty", {32'd0, if1.out_dirty}, 64'h20);
        chk("t1_errs", {32'd0, ef1, ec1, ei1, et1}, 64'd0);
        pop1();
        chk("t1_pop", {63'd0, if1.out_valid}, 64'd0);

        // bad checksum, then good packet
        send_seq(0, 40'hAA_05_3C_00, 4);
        chk("t2_novalid", {63'd0, if1.out_valid}, 64'd0);
        chk("t2_errchk", {56'd0, ec1}, 64'd1);
        send_seq(0, 40'hAA_05_3C_39, 4);
        chk("t2_valid", {63'd0, if1.out_valid}, 64'd1);
        chk("t2_dirty", {32'd0, if1.out_dirty}, 64'h20);
        chk("t2_data", {56'd0, if1.out_data[47:40]}, 64'h3C);
        pop1();

        // channel out of range, then framing error
        send_seq(0, 40'hAA_20_11_31, 4);
        chk("t3_errchid", {56'd0, ei1}, 64'd1);
        chk("t3_novalid", {63'd0, if1.out_valid}, 64'd0);
        send_byte(0, 8'h55, 1'b0);
        repeat (CYC) @(negedge clk);
        chk("t3_errframe", {56'd0, ef1}, 64'd1);
        chk("t3_errchk", {56'd0, ec1}, 64'd1);

        // coalescing while consumer stalls
        send_seq(0, 40'hAA_01_10_11, 4);
        chk("t4_valid", {63'd0, if1.out_valid}, 64'd1);
        chk("t4_dirty1", {32'd0, if1.out_dirty}, 64'h2);
        chk("t4_ch1a", {56'd0, if1.out_data[15:8]}, 64'h10);
        send_seq(0, 40'hAA_02_20_22, 4);
        send_seq(0, 40'hAA_01_11_10, 4);
        chk("t4_hold_dirty", {32'd0, if1.out_dirty}, 64'h2);
        chk("t4_hold_ch1", {56'd0, if1.out_data[15:8]}, 64'h10);
        pop1();
        chk("t4_valid2", {63'd0, if1.out_valid}, 64'd1);
        chk("t4_dirty2", {32'd0, if1.out_dirty}, 64'h6);
        chk("t4_ch1b", {56'd0, if1.out_data[15:8]}, 64'h11);
        chk("t4_ch2", {56'd0, if1.out_data[23:16]}, 64'h20);
        chk("t4_ch5", {56'd0, if1.out_data[47:40]}, 64'h3C);
        pop1();
        chk("t4_pop", {63'd0, if1.out_valid}, 64'd0);
        chk("t4_noto", {56'd0, et1}, 64'd0);

        // two-byte samples and inter-byte timeout
        send_seq(1, 40'hAA_03_12_34_25, 5);
        chk("t5_valid", {63'd0, if2.out_valid}, 64'd1);
        chk("t5_data", {48'd0, if2.out_data[63:48]}, 64'h1234);
        chk("t5_dirty", {32'd0, if2.out_dirty}, 64'h8);
        chk("t5_noto", {56'd0, et2}, 64'd0);
        send_seq(1, 40'hAA_03_12, 3);
        repeat (25 * CYC) @(negedge clk);
        chk("t5_timeout", {56'd0, et2}, 64'd1);
        chk("t5_errchk", {56'd0, ec2}, 64'd0);

        // glitch shorter than half a bit is rejected
        rx1 = 1'b0;
        repeat (4) @(negedge clk);
        rx1 = 1'b1;
        repeat (2 * CYC) @(negedge clk);
        send_seq(0, 40'hAA_07_5A_5D, 4);
        chk("t6_glitch_frame", {56'd0, ef1}, 64'd1);
        chk("t6_glitch_dirty", {32'd0, if1.out_dirty}, 64'h80);
        chk("t6_glitch_data", {56'd0, if1.out_data[63:56]}, 64'h5A);
        pop1();

        // reset in the middle of a packet
        send_seq(0, 40'hAA_04, 2);
        rx1 = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rx1 = 1'b1;
        chk("t6_rst_valid", {63'd0, if1.out_valid}, 64'd0);
        chk("t6_rst_data", {63'd0, |if1.out_data}, 64'd0);
        chk("t6_rst_errs", {32'd0, ef1, ec1, ei1, et1}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * CYC) @(negedge clk);
        send_seq(0, 40'hAA_04_55_51, 4);
        chk("t6_after_valid", {63'd0, if1.out_valid}, 64'd1);
        chk("t6_after_dirty", {32'd0, if1.out_dirty}, 64'h10);
        chk("t6_after_data", {56'd0, if1.out_data[39:32]}, 64'h55);
        chk("t6_after_errs", {32'd0, ef1, ec1, ei1, et1}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
